// File: rtl/div_pkg.sv
// Shared types and helpers for the divider arbiter: tag carried alongside each op
// and the round-robin picker.
package div_pkg;

  localparam int unsigned DEF_DIVIDEND = 4;
  localparam int unsigned DEF_DIVISOR  = 2;
  localparam int unsigned DEF_NREQ     = 4;
  localparam int unsigned ID_W         = $clog2(DEF_NREQ);

  typedef struct packed {
    logic            valid;
    logic            dz;
    logic [ID_W-1:0] id;
  } div_tag_t;

  // One-hot of the first set bit in req[n-1:0], searching upward from ptr with wrap.
  function automatic logic [DEF_NREQ-1:0] rr_pick(input logic [DEF_NREQ-1:0] req,
                                                  input logic [ID_W-1:0]     ptr,
                                                  input int unsigned         n);
    logic            found;
    logic [ID_W-1:0] sel;
    rr_pick = '0;
    found   = 1'b0;
    for (int unsigned k = 0; k < DEF_NREQ; k++) begin
      sel = ID_W'((int'(ptr) + k) % n);
      if (!found && (k < n) && req[sel]) begin
        rr_pick[sel] = 1'b1;
        found        = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/pipelinediv.sv
// Fully pipelined restoring divider: one quotient bit per stage, DIVIDEND stages,
// result appears DIVIDEND edges after the operands are presented. No reset on datapath.
module pipelinediv #(
  parameter int unsigned DIVIDEND = 4,
  parameter int unsigned DIVISOR  = 2
) (
  input  logic                clock,
  input  logic [DIVIDEND-1:0] dividend,
  input  logic [DIVISOR-1:0]  divisor,
  output logic [DIVIDEND-1:0] quotient,
  output logic [DIVISOR-1:0]  remainder
);

  logic [DIVIDEND-1:0] q_s [DIVIDEND];
  logic [DIVISOR-1:0]  r_s [DIVIDEND];
  logic [DIVISOR-1:0]  d_s [DIVIDEND-1];

  // Shift the next dividend bit into the partial remainder and try to subtract.
  function automatic logic [DIVIDEND+DIVISOR-1:0] step(input logic [DIVIDEND-1:0] q,
                                                       input logic [DIVISOR-1:0]  r,
                                                       input logic [DIVISOR-1:0]  d);
    logic [DIVISOR:0]    trial;
    logic [DIVISOR-1:0]  r_n;
    logic                bit_n;
    trial = {r, q[DIVIDEND-1]};
    if (trial >= {1'b0, d}) begin
      r_n   = DIVISOR'(trial - {1'b0, d});
      bit_n = 1'b1;
    end else begin
      r_n   = trial[DIVISOR-1:0];
      bit_n = 1'b0;
    end
    step = {q[DIVIDEND-2:0], bit_n, r_n};
  endfunction

  always_ff @(posedge clock) begin
    {q_s[0], r_s[0]} <= step(dividend, '0, divisor);
    d_s[0]           <= divisor;
    for (int unsigned k = 1; k < DIVIDEND; k++) begin
      {q_s[k], r_s[k]} <= step(q_s[k-1], r_s[k-1], d_s[k-1]);
    end
    for (int unsigned k = 1; k < DIVIDEND - 1; k++) begin
      d_s[k] <= d_s[k-1];
    end
  end

  assign quotient  = q_s[DIVIDEND-1];
  assign remainder = r_s[DIVIDEND-1];

endmodule

// File: rtl/div_arbiter.sv
// Round-robin sharing of one pipelined divider among NREQ requesters, with a tag pipe
// that routes each result back to its owner and a per-requester in-flight cap.
module div_arbiter
  import div_pkg::*;
#(
  parameter int unsigned DIVIDEND = DEF_DIVIDEND,
  parameter int unsigned DIVISOR  = DEF_DIVISOR,
  parameter int unsigned NREQ     = DEF_NREQ,
  parameter int unsigned LATENCY  = DEF_DIVIDEND,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic [NREQ-1:0]          req_valid,
  output logic [NREQ-1:0]          req_ready,
  input  logic [NREQ*DIVIDEND-1:0] req_dividend,
  input  logic [NREQ*DIVISOR-1:0]  req_divisor,
  output logic [NREQ-1:0]          rsp_valid,
  output logic [DIVIDEND-1:0]      rsp_quotient,
  output logic [DIVISOR-1:0]       rsp_remainder,
  output logic                     rsp_dz,
  output logic                     busy
);

  localparam int unsigned CW = $clog2(MAX_OUT + 1);

  logic [DEF_NREQ-1:0] req_ext, pick;
  logic [NREQ-1:0]     grant;
  logic [ID_W-1:0]     rr_ptr, grant_id;
  logic                accept;
  logic [DIVIDEND-1:0] sel_dvd, iss_dvd, div_dvd, div_q;
  logic [DIVISOR-1:0]  sel_dvs, iss_dvs, div_dvs, div_r;
  logic [CW-1:0]       cnt [NREQ];
  div_tag_t            iss_tag, tag_out;
  div_tag_t            tag_pipe [LATENCY];

  always_comb begin
    req_ext = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      req_ext[i] = req_valid[i] && (cnt[i] < CW'(MAX_OUT));
    end
    pick     = rr_pick(req_ext, rr_ptr, NREQ);
    grant    = reset_n ? pick[NREQ-1:0] : '0;
    grant_id = '0;
    sel_dvd  = '0;
    sel_dvs  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (grant[i]) begin
        grant_id = ID_W'(i);
        sel_dvd  = req_dividend[i*DIVIDEND +: DIVIDEND];
        sel_dvs  = req_divisor[i*DIVISOR +: DIVISOR];
      end
    end
  end

  assign accept    = |grant;
  assign req_ready = grant;
  assign tag_out   = tag_pipe[LATENCY-1];

  // An idle slot feeds a harmless 0/1 so the divider never sees stale garbage.
  assign div_dvd = iss_tag.valid ? iss_dvd : '0;
  assign div_dvs = iss_tag.valid ? iss_dvs : DIVISOR'(1);

  always_ff @(posedge clock) begin
    iss_dvd <= sel_dvd;
    iss_dvs <= sel_dvs;
  end

  pipelinediv #(.DIVIDEND(DIVIDEND), .DIVISOR(DIVISOR)) u_div (
    .clock    (clock),
    .dividend (div_dvd),
    .divisor  (div_dvs),
    .quotient (div_q),
    .remainder(div_r)
  );

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      rr_ptr        <= '0;
      iss_tag       <= '0;
      rsp_valid     <= '0;
      rsp_quotient  <= '0;
      rsp_remainder <= '0;
      rsp_dz        <= 1'b0;
      for (int unsigned k = 0; k < LATENCY; k++) tag_pipe[k] <= '0;
      for (int unsigned i = 0; i < NREQ; i++)    cnt[i]      <= '0;
    end else begin
      if (accept) begin
        rr_ptr <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
      iss_tag.valid <= accept;
      iss_tag.dz    <= accept && (sel_dvs == '0);
      iss_tag.id    <= grant_id;
      tag_pipe[0]   <= iss_tag;
      for (int unsigned k = 1; k < LATENCY; k++) tag_pipe[k] <= tag_pipe[k-1];

      for (int unsigned i = 0; i < NREQ; i++) begin
        rsp_valid[i] <= tag_out.valid && (tag_out.id == ID_W'(i));
      end
      rsp_quotient  <= !tag_out.valid ? '0 : (tag_out.dz ? '1 : div_q);
      rsp_remainder <= (!tag_out.valid || tag_out.dz) ? '0 : div_r;
      rsp_dz        <= tag_out.valid && tag_out.dz;

      // Accept and response for the same requester in one cycle cancel out.
      for (int unsigned i = 0; i < NREQ; i++) begin
        if (grant[i] && !(tag_out.valid && (tag_out.id == ID_W'(i)))) begin
          cnt[i] <= cnt[i] + 1'b1;
        end else if (!grant[i] && tag_out.valid && (tag_out.id == ID_W'(i))) begin
          cnt[i] <= cnt[i] - 1'b1;
        end
      end
    end
  end

  always_comb begin
    busy = iss_tag.valid;
    for (int unsigned k = 0; k < LATENCY; k++) busy = busy | tag_pipe[k].valid;
  end

endmodule

// File: tb/tb_div_arbiter.sv
// Directed + randomized bench for div_arbiter against a queue-based reference model.
module tb_div_arbiter;

  localparam int DVD = 4;
  localparam int DVS = 2;
  localparam int NR  = 4;
  localparam int LAT = 4;
  localparam int MO  = 2;

  logic              clock = 1'b0;
  logic              reset_n;
  logic [NR-1:0]     req_valid, req_ready, rsp_valid;
  logic [NR*DVD-1:0] req_dividend;
  logic [NR*DVS-1:0] req_divisor;
  logic [DVD-1:0]    rsp_quotient;
  logic [DVS-1:0]    rsp_remainder;
  logic              rsp_dz, busy;

  int vectors     = 0;
  int miscompares = 0;

  typedef struct {
    int due;
    int id;
    int q;
    int r;
    bit dz;
  } exp_t;

  exp_t pend[$];
  int   m_ptr    = 0;
  int   cyc      = 0;
  int   last_acc = -1;

  div_arbiter #(
    .DIVIDEND(DVD), .DIVISOR(DVS), .NREQ(NR), .LATENCY(LAT), .MAX_OUT(MO)
  ) dut (
    .clock        (clock),
    .reset_n      (reset_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_dividend (req_dividend),
    .req_divisor  (req_divisor),
    .rsp_valid    (rsp_valid),
    .rsp_quotient (rsp_quotient),
    .rsp_remainder(rsp_remainder),
    .rsp_dz       (rsp_dz),
    .busy         (busy)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0h expected=%0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic set_op(input int i, input int dvd, input int dvs);
    req_dividend[i*DVD +: DVD] = DVD'(dvd);
    req_divisor[i*DVS +: DVS]  = DVS'(dvs);
  endtask

  task automatic rand_op(input int i);
    set_op(i, $urandom_range(0, 15), $urandom_range(0, 3));
  endtask

  function automatic int outstanding(input int i);
    int n = 0;
    foreach (pend[k]) if (pend[k].id == i && pend[k].due > cyc) n++;
    return n;
  endfunction

  function automatic int model_grant();
    for (int off = 0; off < NR; off++) begin
      int idx = (m_ptr + off) % NR;
      if (req_valid[idx] && outstanding(idx) < MO) return idx;
    end
    return -1;
  endfunction

  // One clock: check outputs against the model, account any accept, advance to next negedge.
  task automatic tick();
    int g, dvd, dvs;
    logic [31:0] erv, eq, er, edz, eb;
    #1;
    g = model_grant();
    chk("req_ready", req_ready, (g >= 0) ? (32'd1 << g) : 32'd0);
    erv = '0; eq = '0; er = '0; edz = '0; eb = '0;
    foreach (pend[k]) begin
      if (pend[k].due == cyc) begin
        erv = 32'd1 << pend[k].id;
        eq  = pend[k].q;
        er  = pend[k].r;
        edz = pend[k].dz;
      end
      if (pend[k].due > cyc) eb = 32'd1;
    end
    chk("rsp_valid", rsp_valid, erv);
    chk("rsp_quotient", rsp_quotient, eq);
    chk("rsp_remainder", rsp_remainder, er);
    chk("rsp_dz", rsp_dz, edz);
    chk("busy", busy, eb);
    while (pend.size() > 0 && pend[0].due <= cyc) void'(pend.pop_front());
    if (g >= 0) begin
      dvd = req_dividend[g*DVD +: DVD];
      dvs = req_divisor[g*DVS +: DVS];
      pend.push_back('{due: cyc + 1 + LAT + 1, id: g,
                       q: (dvs == 0) ? 15 : dvd / dvs,
                       r: (dvs == 0) ? 0 : dvd % dvs,
                       dz: (dvs == 0)});
      m_ptr = (g + 1) % NR;
    end
    last_acc = g;
    @(posedge clock);
    cyc++;
    @(negedge clock);
  endtask

  initial begin
    reset_n      = 1'b0;
    req_valid    = '1;
    req_dividend = '0;
    req_divisor  = '0;
    #3;
    chk("reset_ready", req_ready, 0);
    chk("reset_rsp_valid", rsp_valid, 0);
    chk("reset_busy", busy, 0);
    chk("reset_quotient", rsp_quotient, 0);
    @(negedge clock);
    reset_n   = 1'b1;
    req_valid = '0;

    // All requesters held valid: strict rotation 0,1,2,3,...
    for (int i = 0; i < NR; i++) rand_op(i);
    req_valid = '1;
    for (int n = 0; n < 16; n++) begin
      #1 chk("rr_order", req_ready, 32'd1 << (n % NR));
      tick();
      if (last_acc >= 0) rand_op(last_acc);
    end
    req_valid = '0;
    repeat (8) tick();

    // Requester 0 alone, 13/3.
    set_op(0, 13, 3);
    req_valid = 4'b0001;
    #1 chk("d13_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (5) tick();
    #1;
    chk("d13_valid", rsp_valid, 4'b0001);
    chk("d13_quot", rsp_quotient, 4);
    chk("d13_rem", rsp_remainder, 1);
    chk("d13_dz", rsp_dz, 0);
    repeat (6) tick();

    // Requester 1 alone with valid held: exercises the in-flight cap.
    rand_op(1);
    req_valid = 4'b0010;
    repeat (16) tick();
    req_valid = '0;
    repeat (7) tick();

    // Divide by zero, then 15/1 on requester 2.
    set_op(2, 9, 0);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (5) tick();
    #1;
    chk("dz_valid", rsp_valid, 4'b0100);
    chk("dz_quot", rsp_quotient, 4'hF);
    chk("dz_rem", rsp_remainder, 0);
    chk("dz_flag", rsp_dz, 1);
    set_op(2, 15, 1);
    req_valid = 4'b0100;
    tick();
    req_valid = '0;
    repeat (5) tick();
    #1;
    chk("d15_valid", rsp_valid, 4'b0100);
    chk("d15_quot", rsp_quotient, 15);
    chk("d15_rem", rsp_remainder, 0);
    chk("d15_dz", rsp_dz, 0);
    repeat (3) tick();

    // Randomized traffic; a pending request keeps its operands until accepted.
    for (int n = 0; n < 240; n++) begin
      tick();
      if (last_acc >= 0) begin
        req_valid[last_acc] = 1'($urandom_range(0, 1));
        rand_op(last_acc);
      end
      for (int i = 0; i < NR; i++) begin
        if (!req_valid[i] && $urandom_range(0, 2) == 0) begin
          req_valid[i] = 1'b1;
          rand_op(i);
        end
      end
    end
    req_valid = '0;
    repeat (8) tick();

    // Three ops in flight, then a one-cycle reset drops them.
    for (int i = 0; i < NR; i++) rand_op(i);
    req_valid = '1;
    repeat (3) tick();
    #2;
    reset_n = 1'b0;
    #1;
    chk("mid_rst_ready", req_ready, 0);
    chk("mid_rst_rsp_valid", rsp_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_quotient", rsp_quotient, 0);
    pend.delete();
    m_ptr = 0;
    @(posedge clock);
    cyc++;
    @(negedge clock);
    reset_n   = 1'b1;
    req_valid = '0;
    repeat (8) tick();
    req_valid = '1;
    #1 chk("post_rst_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (8) tick();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
